sound_sched: RTL
================

// Module: sound_sched
// PURPOSE
//  Sequencer for the logo sound effects. Takes one-cycle sound requests (ping, pong, go, stop)
//  from the dynamics block, queues them, and plays each as a timed square-wave tone on the speaker
//  pin, with a fixed silent gap between tones. Sits between dynamic/logo and the board buzzer.
//  Mute gates the pin only; timing is unchanged.
// PARAMETERS
//  TICK_CYC  12000  clk cycles per duration tick (1 ms at 12 MHz)
//  DEPTH     4      request FIFO depth (power of 2, >=2)
//  GAP_TK    20     silent ticks between consecutive tones
//  HP_PING   6000   half-period, clk cycles, code 0 (1 kHz)
//  HP_PONG   12000  half-period, code 1 (500 Hz)
//  HP_GO     3000   half-period, code 2 (2 kHz)
//  HP_STOP   24000  half-period, code 3 (250 Hz)
// PORTS
//  clk       in   1  system clock
//  clr       in   1  reset, asynchronous, active-low
//  snd_req   in   1  request strobe, one cycle, sampled each clk
//  snd_code  in   2  0=ping 1=pong 2=go 3=stop, valid with snd_req
//  mute      in   1  1 forces spk=0
//  spk       out  1  square-wave speaker output
//  busy      out  1  1 when state!=IDLE or FIFO not empty
//  full      out  1  FIFO holds DEPTH entries
//  drop      out  1  one-cycle pulse: request discarded
//  cur_code  out  2  code of tone being played (held through GAP)
// BEHAVIOUR
//  - Reset (clr=0): FSM=IDLE, FIFO empty, all counters 0; spk=0 busy=0 full=0 drop=0 cur_code=0.
//    Takes effect immediately, including mid-tone.
//  - FSM: IDLE -> LOAD (FIFO not empty) -> PLAY -> GAP -> LOAD (FIFO not empty) or IDLE.
//  - LOAD: pop head into cur_code, select HP and duration, clear tick and half-period counters.
//  - Durations in ticks (package constants): ping 50, pong 50, go 200, stop 300.
//  - PLAY lasts exactly DUR*TICK_CYC cycles. spk=0 on entry. spk toggles when the half-period
//    counter reaches HP-1; the counter then wraps to 0.
//  - GAP lasts exactly GAP_TK*TICK_CYC cycles, spk=0.
//  - Latency: a request at cycle N with IDLE and FIFO empty is written at N, LOAD at N+1, PLAY at N+2.
//  - Non-stop request, FIFO not full: push. FIFO full: discard, drop=1 the next cycle.
//    Full with a same-cycle pop (LOAD): accept; no drop.
//  - Stop request (code 3): flush FIFO, abort PLAY/GAP, FSM->LOAD with stop preloaded. Never dropped.
//    A stop during a stop restarts it.
//  - spk = tone_bit & ~mute. Toggling mute does not alter counters or state.
//  - Counters sized by $clog2 of the max HP and of max(DUR,GAP_TK)*TICK_CYC. No overflow is allowed
//    for legal parameters.
// STRUCTURE
//  - Package sound_pkg: typedef snd_code_t (PING, PONG, GO, STOP), state_t (IDLE, LOAD, PLAY, GAP),
//    DUR_* constants, function dur_of(code).
//  - Sub-module snd_fifo: sync FIFO with DEPTH, push/pop/flush/full/empty, ptr wrap via extra MSB.
//  - Top holds the FSM, tick prescaler, duration counter and half-period generator.
// TESTING
//  (bench: TICK_CYC=10, HP_*=2/3/4/5, GAP_TK=2)
//  1. Reset, req ping at cyc 5 -> PLAY at cyc 7. spk toggles every 2 cycles for 500 cycles.
//     GAP 20 cycles, then IDLE, busy=0.
//  2. Queue ping,pong,go back-to-back -> played in order with cur_code 0,1,2.
//     Exact gaps of 20 cycles between tones.
//  3. 6 non-stop reqs while playing (DEPTH=4) -> full=1 after 4, drop pulses on reqs 5 and 6.
//     Only the first 4 are played.
//  4. Stop req mid-PLAY of go with 3 queued -> FIFO empty next cycle, stop tone within 2 cycles.
//     Lasts 3000 cycles, then IDLE.
//  5. mute=1 during PLAY -> spk=0, total tone time unchanged. Unmute resumes in phase.
//  6. clr low mid-PLAY -> spk, busy, full, cur_code = 0 asynchronously.
//     After release, a fresh req plays normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and tone durations for the logo sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    PING = 2'd0,
    PONG = 2'd1,
    GO   = 2'd2,
    STOP = 2'd3
  } snd_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Tone durations in ticks
  localparam int unsigned DUR_PING = 50;
  localparam int unsigned DUR_PONG = 50;
  localparam int unsigned DUR_GO   = 200;
  localparam int unsigned DUR_STOP = 300;
  localparam int unsigned DUR_MAX  = DUR_STOP;

  function automatic int unsigned dur_of(snd_code_t code);
    unique case (code)
      PING:    dur_of = DUR_PING;
      PONG:    dur_of = DUR_PONG;
      GO:      dur_of = DUR_GO;
      default: dur_of = DUR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/snd_fifo.sv
// Small synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module snd_fifo
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  snd_code_t din,
  output snd_code_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  snd_code_t      mem [DEPTH];
  logic [AW:0]    wptr_q, rptr_q;

  assign dout  = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Pointer update; flush wins over push/pop
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage; a push into a full FIFO with a same-cycle pop reuses the slot being read
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sound_sched.sv
// Logo sound sequencer: queues tone requests and plays them as timed square waves.
module sound_sched
  import sound_pkg::*;
#(
  parameter int unsigned TICK_CYC = 12000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GAP_TK   = 20,
  parameter int unsigned HP_PING  = 6000,
  parameter int unsigned HP_PONG  = 12000,
  parameter int unsigned HP_GO    = 3000,
  parameter int unsigned HP_STOP  = 24000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       snd_req,
  input  logic [1:0] snd_code,
  input  logic       mute,
  output logic       spk,
  output logic       busy,
  output logic       full,
  output logic       drop,
  output logic [1:0] cur_code
);

  localparam int unsigned HpA   = (HP_PING > HP_PONG) ? HP_PING : HP_PONG;
  localparam int unsigned HpB   = (HP_GO > HP_STOP) ? HP_GO : HP_STOP;
  localparam int unsigned HpMax = (HpA > HpB) ? HpA : HpB;
  localparam int unsigned TkMax = (DUR_MAX > GAP_TK) ? DUR_MAX : GAP_TK;
  localparam int unsigned HW    = $clog2(HpMax + 1);
  localparam int unsigned TW    = $clog2(TkMax + 1);
  localparam int unsigned PW    = $clog2(TICK_CYC + 1);

  state_t          state_q;
  snd_code_t       cur_q, head;
  logic            stop_pend_q, tone_q, drop_q;
  logic [PW-1:0]   pre_q;
  logic [TW-1:0]   tk_q;
  logic [HW-1:0]   hp_q, hp_sel;
  logic            stop_req, norm_req, push, pop, fifo_full, fifo_empty, tick;
  logic [TW-1:0]   dur_last, gap_last;

  assign stop_req = snd_req && (snd_code_t'(snd_code) == STOP);
  assign norm_req = snd_req && (snd_code_t'(snd_code) != STOP);
  // Loading a non-stop entry frees a slot in the same cycle
  assign pop      = (state_q == LOAD) && !stop_pend_q;
  assign push     = norm_req && (!fifo_full || pop);
  assign tick     = (pre_q == PW'(TICK_CYC - 1));
  assign dur_last = TW'(dur_of(cur_q) - 1);
  assign gap_last = TW'(GAP_TK - 1);

  snd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (stop_req),
    .din   (snd_code_t'(snd_code)),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Half-period select for the tone currently loaded
  always_comb begin
    hp_sel = HW'(HP_PING);
    unique case (cur_q)
      PING: hp_sel = HW'(HP_PING);
      PONG: hp_sel = HW'(HP_PONG);
      GO:   hp_sel = HW'(HP_GO);
      STOP: hp_sel = HW'(HP_STOP);
    endcase
  end

  // Sequencer FSM with prescaler, duration counter and square-wave generator
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      cur_q       <= PING;
      stop_pend_q <= 1'b0;
      tone_q      <= 1'b0;
      drop_q      <= 1'b0;
      pre_q       <= '0;
      tk_q        <= '0;
      hp_q        <= '0;
    end else begin
      drop_q <= norm_req && fifo_full && !pop;
      if (stop_req) begin
        // Stop preempts everything and restarts even if already playing stop
        state_q     <= LOAD;
        cur_q       <= STOP;
        stop_pend_q <= 1'b1;
        tone_q      <= 1'b0;
        pre_q       <= '0;
        tk_q        <= '0;
        hp_q        <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!fifo_empty || push) state_q <= LOAD;
          end
          LOAD: begin
            if (!stop_pend_q) cur_q <= head;
            stop_pend_q <= 1'b0;
            tone_q      <= 1'b0;
            pre_q       <= '0;
            tk_q        <= '0;
            hp_q        <= '0;
            state_q     <= PLAY;
          end
          PLAY: begin
            if (hp_q == hp_sel - HW'(1)) begin
              hp_q   <= '0;
              tone_q <= ~tone_q;
            end else begin
              hp_q <= hp_q + HW'(1);
            end
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
              if (tk_q == dur_last) begin
                // Later assignments override the toggle above
                state_q <= GAP;
                tk_q    <= '0;
                tone_q  <= 1'b0;
                hp_q    <= '0;
              end else begin
                tk_q <= tk_q + TW'(1);
              end
            end
          end
          GAP: begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
              if (tk_q == gap_last) begin
                tk_q    <= '0;
                state_q <= fifo_empty ? IDLE : LOAD;
              end else begin
                tk_q <= tk_q + TW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign spk      = tone_q & ~mute;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign drop     = drop_q;
  assign cur_code = cur_q;

endmodule
